// File: rtl/io_timer.sv
// io_timer: memory-mapped down-counting timer with periodic/one-shot expiry and a level irq.
// Define IO_TIMER_PWM_EN to add the COMPARE register at addr 4 and a registered pwm_out.
module io_timer #(
  parameter int PRESCALE = 1,
  parameter int WIDTH    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq,
  output logic        pwm_out
);

  // Bus handshake: a write is a single-cycle strobe (sel & we) committed on the
  // next rising edge; there is no ready/wait, and reads are combinational.
  logic [2:0]       ctrl_q, ctrl_d;       // {irq_en, auto_reload, en}
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic [15:0]      presc_q, presc_d;

  logic wr, wr_ctrl, wr_load, wr_stat;
  logic tick, tick_eff, expire;

  assign wr      = sel && we;
  assign wr_ctrl = wr && (addr == 3'd0);
  assign wr_load = wr && (addr == 3'd1);
  assign wr_stat = wr && (addr == 3'd3);

  assign tick     = ctrl_q[0] && (presc_q == 16'(PRESCALE - 1));
  // A LOAD write or a stopping CTRL write on a tick edge suppresses the tick.
  assign tick_eff = tick && !wr_load && !(wr_ctrl && !wd[0]);
  assign expire   = tick_eff && (count_q == '0);

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    presc_d   = presc_q;
    expired_d = expired_q;

    if (ctrl_q[0]) presc_d = tick ? 16'd0 : presc_q + 16'd1;

    if (tick_eff) begin
      if (count_q != '0)  count_d   = count_q - WIDTH'(1);
      else if (ctrl_q[1]) count_d   = load_q;
      else                ctrl_d[0] = 1'b0;
    end

    // ctrl_d[0] here already reflects a one-shot expiry, so a re-enable on that edge reloads.
    if (wr_ctrl) begin
      if (wd[0] && !ctrl_d[0]) begin
        count_d = load_q;
        presc_d = 16'd0;
      end
      ctrl_d = wd[2:0];
    end

    if (wr_load) begin
      load_d  = wd[WIDTH-1:0];
      count_d = wd[WIDTH-1:0];
      presc_d = 16'd0;
    end

    if (wr_stat && wd[0]) expired_d = 1'b0;
    if (expire)           expired_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      presc_q   <= presc_d;
    end
  end

`ifdef IO_TIMER_PWM_EN
  logic [WIDTH-1:0] compare_q, compare_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    compare_d = compare_q;
    if (wr && (addr == 3'd4)) compare_d = wd[WIDTH-1:0];
    pwm_d = ctrl_q[0] && (count_q < compare_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      compare_q <= compare_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = 1'b0;
`endif

  always_comb begin
    rd = '0;
    case (addr)
      3'd0: rd = {29'd0, ctrl_q};
      3'd1: rd = 32'(load_q);
      3'd2: rd = 32'(count_q);
      3'd3: rd = {31'd0, expired_q};
`ifdef IO_TIMER_PWM_EN
      3'd4: rd = 32'(compare_q);
`endif
      default: rd = '0;
    endcase
  end

  assign irq = expired_q && ctrl_q[2];

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: one PRESCALE=1/WIDTH=32 instance and one PRESCALE=4/WIDTH=16 instance.
module tb_io_timer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel1, sel4, we;
  logic [2:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd1, rd4;
  logic        irq1, irq4, pwm1, pwm4;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  io_timer #(.PRESCALE(1), .WIDTH(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel1), .we(we), .addr(addr), .wd(wd),
    .rd(rd1), .irq(irq1), .pwm_out(pwm1)
  );

  io_timer #(.PRESCALE(4), .WIDTH(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .sel(sel4), .we(we), .addr(addr), .wd(wd),
    .rd(rd4), .irq(irq4), .pwm_out(pwm4)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bus_write(input int dev, input logic s, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    sel1 = s && (dev == 1);
    sel4 = s && (dev == 4);
    we = 1'b1; addr = a; wd = d;
    @(posedge clk); #1;
    sel1 = 1'b0; sel4 = 1'b0; we = 1'b0; wd = '0;
  endtask

  task automatic wr(input int dev, input logic [2:0] a, input logic [31:0] d);
    bus_write(dev, 1'b1, a, d);
  endtask

  task automatic rd_reg(input int dev, input logic [2:0] a, output logic [31:0] v);
    addr = a; #1;
    v = (dev == 4) ? rd4 : rd1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n = 1'b0;
    step(2);
    for (int a = 0; a < 8; a++) begin
      rd_reg(1, 3'(a), v);
      n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_rd addr=%0d got=%h exp=0", a, v); end
    end
    n_cmp++; if (irq1 !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq1); end
    n_cmp++; if (pwm1 !== 1'b0) begin n_err++; $display("FAIL reset_pwm got=%b exp=0", pwm1); end
    @(negedge clk); rst_n = 1'b1;
    wr(1, 3'd1, 32'd5);
    wr(1, 3'd0, 32'd3);
    step(2);
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd3) begin n_err++; $display("FAIL premid_count got=%0d exp=3", v); end
    #2; rst_n = 1'b0; #1;
    for (int a = 0; a < 4; a++) begin
      rd_reg(1, 3'(a), v);
      n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL midreset_rd addr=%0d got=%h exp=0", a, v); end
    end
    n_cmp++; if (irq1 !== 1'b0 || pwm1 !== 1'b0) begin n_err++; $display("FAIL midreset_out irq=%b pwm=%b exp=0,0", irq1, pwm1); end
    @(negedge clk); rst_n = 1'b1;
    step(3);
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL postreset_count got=%0d exp=0", v); end
    rd_reg(1, 3'd0, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL postreset_ctrl got=%h exp=0", v); end
  endtask

  task automatic test_auto_reload;
    logic [31:0] v;
    logic [31:0] exp_cnt;
    wr(1, 3'd1, 32'd3);
    wr(1, 3'd0, 32'd7);
    for (int i = 0; i < 4; i++) begin
      exp_cnt = 32'(3 - i);
      rd_reg(1, 3'd2, v);
      n_cmp++; if (v !== exp_cnt) begin n_err++; $display("FAIL ar_count i=%0d got=%0d exp=%0d", i, v, exp_cnt); end
      rd_reg(1, 3'd3, v);
      n_cmp++; if (v !== 32'd0 || irq1 !== 1'b0) begin n_err++; $display("FAIL ar_early_status i=%0d got=%0d irq=%b exp=0,0", i, v, irq1); end
      step(1);
    end
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd3) begin n_err++; $display("FAIL ar_reload got=%0d exp=3", v); end
    rd_reg(1, 3'd3, v);
    n_cmp++; if (v !== 32'd1 || irq1 !== 1'b1) begin n_err++; $display("FAIL ar_expired got=%0d irq=%b exp=1,1", v, irq1); end
    wr(1, 3'd3, 32'd1);
    rd_reg(1, 3'd3, v);
    n_cmp++; if (v !== 32'd0 || irq1 !== 1'b0) begin n_err++; $display("FAIL ar_w1c got=%0d irq=%b exp=0,0", v, irq1); end
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd2) begin n_err++; $display("FAIL ar_count_after_clr got=%0d exp=2", v); end
    step(2);
    wr(1, 3'd3, 32'd1);
    rd_reg(1, 3'd3, v);
    n_cmp++; if (v !== 32'd1 || irq1 !== 1'b1) begin n_err++; $display("FAIL col_expiry_vs_clr got=%0d irq=%b exp=1,1", v, irq1); end
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd3) begin n_err++; $display("FAIL col_expiry_count got=%0d exp=3", v); end
    wr(1, 3'd1, 32'd9);
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd9) begin n_err++; $display("FAIL col_load_tick got=%0d exp=9", v); end
    step(1);
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd8) begin n_err++; $display("FAIL load_then_tick got=%0d exp=8", v); end
    wr(1, 3'd0, 32'd4);
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd8) begin n_err++; $display("FAIL col_stop_tick got=%0d exp=8", v); end
    step(2);
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd8) begin n_err++; $display("FAIL stopped_hold got=%0d exp=8", v); end
    n_cmp++; if (irq1 !== 1'b1) begin n_err++; $display("FAIL stopped_irq got=%b exp=1", irq1); end
    wr(1, 3'd3, 32'd0);
    rd_reg(1, 3'd3, v);
    n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL status_w0 got=%0d exp=1", v); end
    wr(1, 3'd3, 32'd1);
    n_cmp++; if (irq1 !== 1'b0) begin n_err++; $display("FAIL final_clr_irq got=%b exp=0", irq1); end
  endtask

  task automatic test_one_shot;
    logic [31:0] v;
    wr(4, 3'd1, 32'hABCD_0002);
    rd_reg(4, 3'd1, v);
    n_cmp++; if (v !== 32'h0000_0002) begin n_err++; $display("FAIL os_load_zext got=%h exp=00000002", v); end
    wr(4, 3'd0, 32'd1);
    step(11);
    rd_reg(4, 3'd3, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL os_not_yet got=%0d exp=0", v); end
    rd_reg(4, 3'd0, v);
    n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL os_ctrl_running got=%h exp=1", v); end
    step(1);
    rd_reg(4, 3'd3, v);
    n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL os_expired got=%0d exp=1", v); end
    rd_reg(4, 3'd0, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL os_ctrl_cleared got=%h exp=0", v); end
    n_cmp++; if (irq4 !== 1'b0) begin n_err++; $display("FAIL os_irq got=%b exp=0", irq4); end
    step(8);
    rd_reg(4, 3'd2, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL os_count_hold got=%0d exp=0", v); end
  endtask

  task automatic test_bus_edges;
    logic [31:0] v;
    bus_write(1, 1'b0, 3'd1, 32'h55);
    bus_write(1, 1'b0, 3'd0, 32'd7);
    rd_reg(1, 3'd1, v);
    n_cmp++; if (v !== 32'd9) begin n_err++; $display("FAIL nosel_load got=%0d exp=9", v); end
    rd_reg(1, 3'd0, v);
    n_cmp++; if (v !== 32'd4) begin n_err++; $display("FAIL nosel_ctrl got=%h exp=4", v); end
    wr(1, 3'd2, 32'h1234);
    rd_reg(1, 3'd2, v);
    n_cmp++; if (v !== 32'd8) begin n_err++; $display("FAIL count_write got=%0d exp=8", v); end
    for (int a = 5; a < 8; a++) wr(1, 3'(a), 32'hFFFF_FFFF);
    for (int a = 5; a < 8; a++) begin
      rd_reg(1, 3'(a), v);
      n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL unmapped_rd addr=%0d got=%h exp=0", a, v); end
    end
    rd_reg(1, 3'd1, v);
    n_cmp++; if (v !== 32'd9) begin n_err++; $display("FAIL unmapped_alias got=%0d exp=9", v); end
    wr(1, 3'd0, 32'hFFFF_FFF8);
    rd_reg(1, 3'd0, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL ctrl_upper_bits got=%h exp=0", v); end
  endtask

  task automatic test_pwm;
    logic [31:0] v;
    logic [31:0] exp_cmp;
    int          highs;
    int          exp_highs;
`ifdef IO_TIMER_PWM_EN
    exp_cmp = 32'd3; exp_highs = 6;
`else
    exp_cmp = 32'd0; exp_highs = 0;
`endif
    wr(1, 3'd1, 32'd9);
    wr(1, 3'd4, 32'd3);
    rd_reg(1, 3'd4, v);
    n_cmp++; if (v !== exp_cmp) begin n_err++; $display("FAIL compare_rd got=%0d exp=%0d", v, exp_cmp); end
    wr(1, 3'd0, 32'd3);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (pwm1 === 1'b1) highs++;
    end
    n_cmp++; if (highs !== exp_highs) begin n_err++; $display("FAIL pwm_duty got=%0d exp=%0d of 20", highs, exp_highs); end
    wr(1, 3'd0, 32'd0);
    step(2);
    n_cmp++; if (pwm1 !== 1'b0) begin n_err++; $display("FAIL pwm_stopped got=%b exp=0", pwm1); end
  endtask

  initial begin
    sel1 = 1'b0; sel4 = 1'b0; we = 1'b0; addr = '0; wd = '0; rst_n = 1'b0;
    test_reset;
    test_auto_reload;
    test_one_shot;
    test_bus_edges;
    test_pwm;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
